// File: rtl/prefix_adder_if.sv
// Valid/ready bundle between an operand producer, the pipelined prefix adder
// and the result consumer. The adder sits on the slave side.
interface prefix_adder_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/prefix_adder_pipe.sv
// Three-stage valid/ready Brent-Kung adder: stage 1 holds bit generate/propagate,
// stage 2 the tree carries, stage 3 the registered sum, carry-out and overflow.
module prefix_adder_pipe #(
   parameter int WIDTH = 16
) (
   input logic           clk,
   input logic           rst,
   prefix_adder_if.slave bus
);
   localparam int LOG = $clog2(WIDTH);
   localparam int NS  = 32'sd2 * LOG;

   logic             rst_done_q, rst_done_d;
   logic             v1_q, v1_d;
   logic [WIDTH-1:0] g1_q, g1_d;
   logic [WIDTH-1:0] p1_q, p1_d;
   logic             cin1_q, cin1_d;
   logic             v2_q, v2_d;
   logic [WIDTH-1:0] p2_q, p2_d;
   logic [WIDTH:0]   c2_q, c2_d;
   logic             v3_q, v3_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             ready3_s, ready2_s, in_ready_s;
   logic             load1_s, load2_s, load3_s;
   logic [WIDTH:0]   carry_s;

   // Prefix tree: cin is folded into bit 0 so every group generate is a carry.
   // Stages 1..LOG are the up-sweep, LOG+1..NS-1 the down-sweep fill-in.
   for (genvar s = 0; s < NS; s++) begin : st
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      if (s == 0) begin : seed
         assign g = {g1_q[WIDTH-1:1], g1_q[0] | (p1_q[0] & cin1_q)};
         assign p = p1_q;
      end else begin : lvl
         for (genvar i = 0; i < WIDTH; i++) begin : bitpos
            localparam int  L    = (s <= LOG) ? (s - 32'sd1) : (NS - 32'sd1 - s);
            localparam int  SPAN = 32'sd1 << L;
            localparam bit  ACT  = (s <= LOG) ?
               (((i + 32'sd1) % (32'sd2 * SPAN)) == 32'sd0) :
               ((((i + 32'sd1) % (32'sd2 * SPAN)) == SPAN) && ((i + 32'sd1) > (32'sd2 * SPAN)));
            if (ACT) begin : bcell
               localparam int J = i - SPAN;
               assign g[i] = st[s-32'sd1].g[i] | (st[s-32'sd1].p[i] & st[s-32'sd1].g[J]);
               assign p[i] = st[s-32'sd1].p[i] & st[s-32'sd1].p[J];
            end else begin : wire_through
               assign g[i] = st[s-32'sd1].g[i];
               assign p[i] = st[s-32'sd1].p[i];
            end
         end
      end
   end

   assign carry_s = {st[NS-1].g, cin1_q};

   // Handshake chain: each stage can take data when empty or when it drains downstream.
   always_comb begin
      ready3_s   = ~v3_q | bus.out_ready;
      ready2_s   = ~v2_q | ready3_s;
      in_ready_s = rst_done_q & (~v1_q | ready2_s);
      load1_s    = bus.in_valid & in_ready_s;
      load2_s    = v1_q & ready2_s;
      load3_s    = v2_q & ready3_s;
   end

   // Next state of every stage; a valid stage that does not advance holds its payload.
   always_comb begin
      rst_done_d = 1'b1;
      v1_d       = load1_s | (v1_q & ~ready2_s);
      v2_d       = load2_s | (v2_q & ~ready3_s);
      v3_d       = load3_s | (v3_q & ~bus.out_ready);
      g1_d       = g1_q;
      p1_d       = p1_q;
      cin1_d     = cin1_q;
      p2_d       = p2_q;
      c2_d       = c2_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      ovf_d      = ovf_q;
      if (load1_s) begin
         g1_d   = bus.a & bus.b;
         p1_d   = bus.a ^ bus.b;
         cin1_d = bus.cin;
      end else begin
         g1_d   = g1_q;
         p1_d   = p1_q;
         cin1_d = cin1_q;
      end
      if (load2_s) begin
         p2_d = p1_q;
         c2_d = carry_s;
      end else begin
         p2_d = p2_q;
         c2_d = c2_q;
      end
      if (load3_s) begin
         sum_d  = p2_q ^ c2_q[WIDTH-1:0];
         cout_d = c2_q[WIDTH];
         ovf_d  = c2_q[WIDTH] ^ c2_q[WIDTH-1];
      end else begin
         sum_d  = sum_q;
         cout_d = cout_q;
         ovf_d  = ovf_q;
      end
   end

   // Pipeline registers; rst_done_q keeps in_ready low until the first edge after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_done_q <= 1'b0;
         v1_q       <= 1'b0;
         g1_q       <= {WIDTH{1'b0}};
         p1_q       <= {WIDTH{1'b0}};
         cin1_q     <= 1'b0;
         v2_q       <= 1'b0;
         p2_q       <= {WIDTH{1'b0}};
         c2_q       <= {(WIDTH+1){1'b0}};
         v3_q       <= 1'b0;
         sum_q      <= {WIDTH{1'b0}};
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         rst_done_q <= rst_done_d;
         v1_q       <= v1_d;
         g1_q       <= g1_d;
         p1_q       <= p1_d;
         cin1_q     <= cin1_d;
         v2_q       <= v2_d;
         p2_q       <= p2_d;
         c2_q       <= c2_d;
         v3_q       <= v3_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = v3_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe at WIDTH=16 and WIDTH=64: the driver pushes
// arithmetic expectations on accept, negedge monitors pop and compare each output.
module tb_prefix_adder_pipe;
   typedef struct packed {
      logic [63:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   exp_t q16[$];
   exp_t q64[$];
   logic        stall_r [2] = '{1'b0, 1'b0};
   logic [66:0] prev_r  [2];

   always #5 clk = ~clk;

   prefix_adder_if #(.WIDTH(16)) b16 ();
   prefix_adder_if #(.WIDTH(64)) b64 ();

   prefix_adder_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
   prefix_adder_pipe #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

   // Reference: plain integer addition, overflow from operand/result sign bits.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic ci, input int w);
      logic [64:0] full;
      logic [63:0] mask;
      exp_t        e;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, ci};
      e.s  = full[63:0] & mask;
      e.co = full[w];
      e.ov = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
      return e;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 7))
         0:       return {64{1'b1}};
         1:       return 64'd0;
         2:       return 64'h8000_0000_0000_8000;
         3:       return 64'h7FFF_FFFF_FFFF_7FFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One bench cycle on DUT id (0: 16-bit, 1: 64-bit): drive at negedge, decide accept at +1.
   task automatic cyc(input int id, input logic iv, input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic ordy, output logic acc);
      @(negedge clk);
      if (id == 0) begin
         b16.in_valid = iv; b16.a = a[15:0]; b16.b = b[15:0]; b16.cin = ci; b16.out_ready = ordy;
      end else begin
         b64.in_valid = iv; b64.a = a; b64.b = b; b64.cin = ci; b64.out_ready = ordy;
      end
      #1;
      if (id == 0) begin
         acc = iv && b16.in_ready;
         if (acc) q16.push_back(model(a, b, ci, 16));
      end else begin
         acc = iv && b64.in_ready;
         if (acc) q64.push_back(model(a, b, ci, 64));
      end
   endtask

   task automatic idle(input int id);
      logic acc;
      cyc(id, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
   endtask

   task automatic drain(input int id);
      int n = 0;
      while (((id == 0) ? q16.size() : q64.size()) != 0 && n < 20) begin
         idle(id);
         n++;
      end
      idle(id);
      check((id == 0) ? "drain16" : "drain64", (id == 0) ? q16.size() : q64.size(), 68'd0);
   endtask

   task automatic mon(input int id, input logic v, input logic r, input logic [63:0] s,
                      input logic co, input logic ov);
      exp_t        e;
      logic [66:0] cur;
      cur = {v, co, ov, s};
      if (rst) begin
         stall_r[id] = 1'b0;
      end else begin
         if (stall_r[id]) check((id == 0) ? "hold16" : "hold64", cur, prev_r[id]);
         if (v && r) begin
            if (((id == 0) ? q16.size() : q64.size()) == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result%0d actual=%0h required=none", id, s);
            end else begin
               if (id == 0) e = q16.pop_front();
               else         e = q64.pop_front();
               check((id == 0) ? "result16" : "result64", {1'b1, co, ov, s}, {1'b1, e.co, e.ov, e.s});
            end
         end
         stall_r[id] = v && !r;
         prev_r[id]  = cur;
      end
   endtask

   always @(negedge clk) begin
      #2;
      mon(0, b16.out_valid, b16.out_ready, {48'd0, b16.sum}, b16.cout, b16.ovf);
   end

   always @(negedge clk) begin
      #2;
      mon(1, b64.out_valid, b64.out_ready, b64.sum, b64.cout, b64.ovf);
   end

   task automatic rand_run(input int id, input int n);
      int   acc_n = 0;
      int   cyc_n = 0;
      logic acc;
      while (acc_n < n && cyc_n < 3 * n) begin
         cyc(id, $urandom_range(0, 3) != 0, pick(), pick(), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0, acc);
         if (acc) acc_n++;
         cyc_n++;
      end
      check((id == 0) ? "rand_accepts16" : "rand_accepts64", acc_n, n);
      drain(id);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   n;
      rst = 1'b0;
      b16.in_valid = 1'b0; b16.a = 16'd0; b16.b = 16'd0; b16.cin = 1'b0; b16.out_ready = 1'b0;
      b64.in_valid = 1'b0; b64.a = 64'd0; b64.b = 64'd0; b64.cin = 1'b0; b64.out_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_state16", {b16.in_ready, b16.out_valid, b16.cout, b16.ovf, b16.sum}, 68'd0);
      check("reset_state64", {b64.in_ready, b64.out_valid, b64.cout, b64.ovf, b64.sum}, 68'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1 check("in_ready_after_release", b16.in_ready, 68'd1);

      // Full-width carry ripple with exact three-edge latency.
      cyc(0, 1'b1, 64'hFFFF, 64'h0001, 1'b0, 1'b1, acc);
      check("ripple_accept", acc, 68'd1);
      idle(0); check("ripple_lat1", b16.out_valid, 68'd0);
      idle(0); check("ripple_lat2", b16.out_valid, 68'd0);
      idle(0); check("ripple_result", {b16.out_valid, b16.cout, b16.ovf, b16.sum}, {1'b1, 1'b1, 1'b0, 16'h0000});

      // Signed overflow both directions, back to back.
      cyc(0, 1'b1, 64'h7FFF, 64'h0001, 1'b0, 1'b1, acc);
      cyc(0, 1'b1, 64'h8000, 64'h8000, 1'b1, 1'b1, acc);
      idle(0);
      idle(0); check("ovf_pos", {b16.out_valid, b16.cout, b16.ovf, b16.sum}, {1'b1, 1'b0, 1'b1, 16'h8000});
      idle(0); check("ovf_neg", {b16.out_valid, b16.cout, b16.ovf, b16.sum}, {1'b1, 1'b1, 1'b1, 16'h0001});

      // Eight back-to-back adds must come out as eight consecutive valid cycles.
      for (int i = 0; i < 12; i++) begin
         if (i < 8) begin
            cyc(0, 1'b1, pick(), pick(), $urandom_range(0, 1) == 1, 1'b1, acc);
            check("stream_accept", acc, 68'd1);
         end else begin
            idle(0);
         end
         if (i >= 3 && i <= 10) check("stream_valid", b16.out_valid, 68'd1);
         if (i == 11) check("stream_end", b16.out_valid, 68'd0);
      end

      // Backpressure: three accepts fill the pipe, then in_ready drops.
      n = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(0, 1'b1, pick(), pick(), $urandom_range(0, 1) == 1, 1'b0, acc);
         if (acc) n++;
      end
      check("bp_accepts", n, 68'd3);
      check("bp_in_ready_low", b16.in_ready, 68'd0);
      check("bp_out_valid", b16.out_valid, 68'd1);
      cyc(0, 1'b1, pick(), pick(), 1'b0, 1'b1, acc);
      check("bp_release_ready", b16.in_ready, 68'd1);
      drain(0);

      // Reset with three results in flight.
      for (int i = 0; i < 3; i++) cyc(0, 1'b1, pick(), pick(), 1'b1, 1'b0, acc);
      @(negedge clk);
      rst = 1'b1;
      b16.in_valid = 1'b0;
      q16.delete();
      q64.delete();
      #1 check("rst_mid_outputs", {b16.in_ready, b16.out_valid, b16.cout, b16.ovf, b16.sum}, 68'd0);
      @(negedge clk);
      check("rst_mid_hold", {b16.in_ready, b16.out_valid, b16.cout, b16.ovf, b16.sum}, 68'd0);
      rst = 1'b0;
      cyc(0, 1'b1, 64'h0003, 64'h0004, 1'b0, 1'b1, acc);
      check("post_rst_accept", acc, 68'd1);
      idle(0); check("post_rst_lat1", b16.out_valid, 68'd0);
      idle(0); check("post_rst_lat2", b16.out_valid, 68'd0);
      idle(0); check("post_rst_result", {b16.out_valid, b16.cout, b16.ovf, b16.sum}, {1'b1, 1'b0, 1'b0, 16'h0007});
      drain(0);

      // Random regression on both widths with random valid/ready.
      fork
         rand_run(0, 10000);
         rand_run(1, 10000);
      join

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
